ps2_byte_receiver: RTL and testbench

- Receives one 11-bit PS/2 device-to-host frame (start, 8 data LSB-first, odd parity, stop) from the mouse clock/data lines.
- Delivers the decoded byte with a one-cycle ready pulse and a 2-bit error code.
- Sits directly upstream of the mouse master state machine and drives its READ_ENABLE / BYTE_READ / BYTE_ERROR_CODE / BYTE_READY port group.
- Runs entirely in the CLK domain: the PS/2 lines are sampled, never used as clocks.

---
 rtl/ps2_pkg.sv | 27 ++
 rtl/ps2_input_sync.sv | 35 +++
 rtl/ps2_byte_receiver.sv | 88 ++++++++
 tb/tb_ps2_byte_receiver.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared PS/2 types and constants for the mouse receive/transmit path.
package ps2_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRxData,
        StRxParity,
        StRxStop
    } ps2_state_t;

    localparam logic [1:0] ERR_NONE   = 2'b00;
    localparam logic [1:0] ERR_PARITY = 2'b01;
    localparam logic [1:0] ERR_STOP   = 2'b10;

    localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 50000;

    // Odd parity over data+parity is correct; a low stop bit is a framing error.
    function automatic logic [1:0] frame_error(input logic [7:0] data, input logic parity,
                                               input logic stop);
        logic [1:0] code;
        code = ERR_NONE;
        if (!(^{data, parity})) code = code | ERR_PARITY;
        if (!stop)              code = code | ERR_STOP;
        return code;
    endfunction

endpackage

// File: rtl/ps2_input_sync.sv
// Synchronises the PS/2 clock and data lines into the system clock domain and
// flags falling edges of the PS/2 clock.
module ps2_input_sync (
    input  logic clk,
    input  logic reset,
    input  logic ps2_clk,
    input  logic ps2_data,
    output logic fall,
    output logic data_sync
);

    logic clk_s1, clk_s2, clk_s3;
    logic data_s1, data_s2;

    // Reset to the idle-high level so no spurious edge follows reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            clk_s1  <= 1'b1;
            clk_s2  <= 1'b1;
            clk_s3  <= 1'b1;
            data_s1 <= 1'b1;
            data_s2 <= 1'b1;
        end else begin
            clk_s1  <= ps2_clk;
            clk_s2  <= clk_s1;
            clk_s3  <= clk_s2;
            data_s1 <= ps2_data;
            data_s2 <= data_s1;
        end
    end

    assign fall      = clk_s3 & ~clk_s2;
    assign data_sync = data_s2;

endmodule

// File: rtl/ps2_byte_receiver.sv
// Receives one 11-bit PS/2 device-to-host frame and presents the byte with a
// one-cycle ready pulse and a parity/stop error code.
module ps2_byte_receiver
    import ps2_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       CLK_MOUSE_IN,
    input  logic       DATA_MOUSE_IN,
    input  logic       READ_ENABLE,
    output logic [7:0] BYTE_READ,
    output logic [1:0] BYTE_ERROR_CODE,
    output logic       BYTE_READY
);

    localparam int unsigned TimeoutWidth = $clog2(TIMEOUT_CYCLES);
    localparam logic [TimeoutWidth-1:0] TimeoutLast = TimeoutWidth'(TIMEOUT_CYCLES - 1);

    logic                    fall;
    logic                    data_sync;
    ps2_state_t              state;
    logic [2:0]              bit_cnt;
    logic [7:0]              shift;
    logic                    parity;
    logic [TimeoutWidth-1:0] timeout_cnt;

    ps2_input_sync u_sync (
        .clk       (CLK),
        .reset     (RESET),
        .ps2_clk   (CLK_MOUSE_IN),
        .ps2_data  (DATA_MOUSE_IN),
        .fall      (fall),
        .data_sync (data_sync)
    );

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state           <= StIdle;
            bit_cnt         <= '0;
            shift           <= '0;
            parity          <= 1'b0;
            timeout_cnt     <= '0;
            BYTE_READ       <= 8'h00;
            BYTE_ERROR_CODE <= ERR_NONE;
            BYTE_READY      <= 1'b0;
        end else begin
            BYTE_READY <= 1'b0;
            // A falling edge always takes priority over timeout expiry.
            if (fall) begin
                timeout_cnt <= '0;
                unique case (state)
                    StIdle: begin
                        if (READ_ENABLE && !data_sync) begin
                            state   <= StRxData;
                            bit_cnt <= '0;
                        end
                    end
                    StRxData: begin
                        shift[bit_cnt] <= data_sync;
                        bit_cnt        <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) state <= StRxParity;
                    end
                    StRxParity: begin
                        parity <= data_sync;
                        state  <= StRxStop;
                    end
                    StRxStop: begin
                        BYTE_READ       <= shift;
                        BYTE_ERROR_CODE <= frame_error(shift, parity, data_sync);
                        BYTE_READY      <= 1'b1;
                        state           <= StIdle;
                    end
                    default: state <= StIdle;
                endcase
            end else if (state != StIdle) begin
                if (timeout_cnt == TimeoutLast) begin
                    state       <= StIdle;
                    timeout_cnt <= '0;
                end else begin
                    timeout_cnt <= timeout_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_ps2_byte_receiver.sv
// Directed and randomised frames against a frame-level reference model of the
// PS/2 byte receiver.
module tb_ps2_byte_receiver;

    localparam int unsigned Timeout = 200;
    localparam int          Half    = 20;

    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic       CLK_MOUSE_IN = 1'b1;
    logic       DATA_MOUSE_IN = 1'b1;
    logic       READ_ENABLE = 1'b1;
    logic [7:0] BYTE_READ;
    logic [1:0] BYTE_ERROR_CODE;
    logic       BYTE_READY;

    int         n_checks = 0;
    int         n_fail = 0;
    int         pulses = 0;
    int         exp_pulses = 0;
    logic [7:0] exp_byte = 8'h00;
    logic [1:0] exp_code = 2'b00;

    ps2_byte_receiver #(
        .TIMEOUT_CYCLES (Timeout)
    ) dut (
        .CLK             (CLK),
        .RESET           (RESET),
        .CLK_MOUSE_IN    (CLK_MOUSE_IN),
        .DATA_MOUSE_IN   (DATA_MOUSE_IN),
        .READ_ENABLE     (READ_ENABLE),
        .BYTE_READ       (BYTE_READ),
        .BYTE_ERROR_CODE (BYTE_ERROR_CODE),
        .BYTE_READY      (BYTE_READY)
    );

    always #5 CLK = ~CLK;

    always @(negedge CLK) if (BYTE_READY === 1'b1) pulses++;

    function automatic logic [1:0] model_code(input logic [7:0] b, input logic p, input logic s);
        int ones;
        ones = $countones(b) + int'(p);
        return {s == 1'b0, (ones % 2) == 0};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One PS/2 bit; on the stop bit, checks the ready pulse lands on the 3rd edge.
    task automatic ps2_bit(input logic v, input bit chk, input logic exp_ready);
        @(negedge CLK) DATA_MOUSE_IN = v;
        repeat (Half) @(negedge CLK);
        CLK_MOUSE_IN = 1'b0;
        if (chk) begin
            @(posedge CLK);
            @(posedge CLK) #1 check("ready_edge2", 32'(BYTE_READY), 32'(1'b0));
            @(posedge CLK) #1 check("ready_edge3", 32'(BYTE_READY), 32'(exp_ready));
            @(posedge CLK) #1 check("ready_edge4", 32'(BYTE_READY), 32'(1'b0));
            repeat (Half - 4) @(negedge CLK);
        end else begin
            repeat (Half) @(negedge CLK);
        end
        CLK_MOUSE_IN = 1'b1;
    endtask

    task automatic check_outputs(input string tag);
        check({tag, "_byte"}, 32'(BYTE_READ), 32'(exp_byte));
        check({tag, "_code"}, 32'(BYTE_ERROR_CODE), 32'(exp_code));
        check({tag, "_pulses"}, 32'(pulses), 32'(exp_pulses));
    endtask

    task automatic frame(input logic [7:0] b, input logic p, input logic s, input int nbits,
                         input logic deliver, input string tag);
        logic [10:0] f;
        f = {s, p, b, 1'b0};
        for (int i = 0; i < nbits; i++) ps2_bit(f[i], i == 10, deliver);
        if (deliver && nbits == 11) begin
            exp_byte = b;
            exp_code = model_code(b, p, s);
            exp_pulses++;
        end
        repeat (5) @(negedge CLK);
        check_outputs(tag);
    endtask

    initial begin
        logic [7:0] rb;
        logic       rp, rs;

        repeat (3) @(negedge CLK);
        RESET = 1'b0;
        @(negedge CLK);
        check("reset_ready", 32'(BYTE_READY), 32'(1'b0));
        check_outputs("reset");

        frame(8'hFA, 1'b1, 1'b1, 11, 1'b1, "fa_ok");
        frame(8'hAA, 1'b0, 1'b1, 11, 1'b1, "aa_parity");
        frame(8'h00, 1'b1, 1'b0, 11, 1'b1, "00_stop");
        frame(8'h00, 1'b0, 1'b0, 11, 1'b1, "00_both");

        // Start plus five data bits, then let the frame time out.
        frame(8'h2D, 1'b0, 1'b1, 6, 1'b0, "partial");
        repeat (Timeout + 10) @(negedge CLK);
        check_outputs("timeout");
        frame(8'h08, 1'b0, 1'b1, 11, 1'b1, "08_after_to");

        READ_ENABLE = 1'b0;
        frame(8'h55, 1'b1, 1'b1, 11, 1'b0, "re_low");
        READ_ENABLE = 1'b1;
        frame(8'h3C, 1'b1, 1'b1, 11, 1'b1, "3c_re_high");

        // Interrupted frame: remaining bits are all ones so none looks like a start.
        frame(8'hF0, 1'b1, 1'b1, 5, 1'b0, "pre_reset");
        @(negedge CLK) RESET = 1'b1;
        @(negedge CLK) RESET = 1'b0;
        exp_byte = 8'h00;
        exp_code = 2'b00;
        check("midreset_ready", 32'(BYTE_READY), 32'(1'b0));
        check_outputs("midreset");
        for (int i = 0; i < 6; i++) ps2_bit(1'b1, i == 5, 1'b0);
        repeat (5) @(negedge CLK);
        check_outputs("after_reset_tail");
        frame(8'hF4, 1'b0, 1'b1, 11, 1'b1, "f4_ok");

        for (int n = 0; n < 8; n++) begin
            rb = 8'($urandom);
            rp = 1'($urandom_range(0, 1));
            rs = 1'($urandom_range(0, 1));
            frame(rb, rp, rs, 11, 1'b1, "random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
